// File: rtl/seg7_scan_driver.sv
// Signed 8-bit value to 4-digit multiplexed 7-segment display.
// Layout: digit3 sign, digit2 hundreds, digit1 tens, digit0 ones.
// Binary-to-BCD uses a double-dabble shifter (one iteration per clock).
//
// state | meaning
// IDLE  | waiting for load; display registers hold the last result
// CONV  | eight double-dabble iterations in progress, busy high
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] value,
    output logic       busy,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic {IDLE, CONV} state_t;

    logic [1:0]       rst_sync_q;
    logic             rst_n_int;
    state_t           state_q;
    logic             busy_q;
    logic [19:0]      sh_q;
    logic [2:0]       iter_q;
    logic             sign_q;
    logic             disp_sign_q;
    logic [11:0]      disp_bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       anode_q;
    logic [6:0]       seg_q;

    logic [7:0]       mag;
    logic [19:0]      dabble_adj;
    logic [19:0]      sh_d;
    logic             cnt_wrap;
    logic [1:0]       idx_d;
    logic [6:0]       seg_d;

    function automatic logic [6:0] digit_pat(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Reset asserts asynchronously but releases only after two clean edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= 2'b00;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_int = rst_sync_q[1];

    // |value| fits 8 unsigned bits, including -128 -> 128.
    assign mag = value[7] ? (~value + 8'd1) : value;

    // One double-dabble step: add 3 to ones/tens nibbles >= 5, then shift left.
    // The hundreds nibble never exceeds 2 for an 8-bit input, so it needs no adjust.
    always_comb begin
        dabble_adj = sh_q;
        if (sh_q[11:8] >= 4'd5)  dabble_adj[11:8]  = sh_q[11:8] + 4'd3;
        if (sh_q[15:12] >= 4'd5) dabble_adj[15:12] = sh_q[15:12] + 4'd3;
        sh_d = dabble_adj << 1;
    end

    // Conversion FSM; the display registers change only when the last step lands.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            sh_q        <= '0;
            iter_q      <= '0;
            sign_q      <= 1'b0;
            disp_sign_q <= 1'b0;
            disp_bcd_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        sign_q  <= value[7];
                        sh_q    <= {12'd0, mag};
                        iter_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    sh_q   <= sh_d;
                    iter_q <= iter_q + 3'd1;
                    if (iter_q == 3'd7) begin
                        disp_bcd_q  <= sh_d[19:8];
                        disp_sign_q <= sign_q;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Next scan position and the segment pattern for that position.
    always_comb begin
        cnt_wrap = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;
        seg_d    = SEG_BLANK;
        case (idx_d)
            2'd0: seg_d = digit_pat(disp_bcd_q[3:0]);
            2'd1: if (disp_bcd_q[11:8] != 4'd0 || disp_bcd_q[7:4] != 4'd0)
                      seg_d = digit_pat(disp_bcd_q[7:4]);
            2'd2: if (disp_bcd_q[11:8] != 4'd0)
                      seg_d = digit_pat(disp_bcd_q[11:8]);
            2'd3: if (disp_sign_q) seg_d = SEG_MINUS;
            default: seg_d = SEG_BLANK;
        endcase
    end

    // Refresh scanner; anode and seg are registered together from the same index.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            anode_q <= 4'b1110;
            seg_q   <= 7'b1000000;
        end else begin
            cnt_q   <= cnt_wrap ? '0 : cnt_q + 1'b1;
            idx_q   <= idx_d;
            anode_q <= ~(4'b0001 << idx_d);
            seg_q   <= seg_d;
        end
    end

    assign busy  = busy_q;
    assign anode = anode_q;
    assign seg   = seg_q;
    assign dp    = 1'b1;

endmodule
